// File: rtl/rf_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_seq_pkg
// Description : Shared opcode and FSM state encodings for the register-file
//               operation sequencer, plus an opcode legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_seq_pkg;

    // Command opcodes (4-bit). Codes above OP_READ are illegal.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LUI  = 4'd8;
    localparam logic [3:0] OP_READ = 4'd9;

    // Sequencer FSM encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_WB   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_READ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : rf_seq_alu
// Description : Combinational execute stage for the sequencer.
//               (op, a, b, imm) -> (result, signed overflow, illegal-op error)
// Ports       : i_op     opcode
//               i_a/i_b  register operands
//               i_imm    immediate (sign-extended for ADDI, shifted for LUI)
//               o_result result (0 for illegal opcodes)
//               o_ovf    signed overflow for ADD/SUB/ADDI
//               o_err    illegal opcode
// Revision    : 1.0 - initial release
// ============================================================================
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [IMM_W-1:0]  i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_ovf,
    output logic              o_err
);

    localparam int c_lui_shift = 16;
    localparam int c_msb       = DATA_W - 1;

    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_lui;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_addi;
    logic              w_lt_s;
    logic              w_lt_u;

    assign w_imm_sext = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
    assign w_lui      = DATA_W'({i_imm, {c_lui_shift{1'b0}}});
    assign w_sum      = i_a + i_b;
    assign w_diff     = i_a - i_b;
    assign w_addi     = i_a + w_imm_sext;
    assign w_lt_s     = $signed(i_a) < $signed(i_b);
    assign w_lt_u     = i_a < i_b;

    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        o_err    = !op_is_legal(i_op);
        case (i_op)
            OP_ADD: begin
                o_result = w_sum;
                o_ovf    = (i_a[c_msb] == i_b[c_msb]) && (w_sum[c_msb] != i_a[c_msb]);
            end
            OP_SUB: begin
                o_result = w_diff;
                o_ovf    = (i_a[c_msb] != i_b[c_msb]) && (w_diff[c_msb] != i_a[c_msb]);
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_lt_s};
            OP_SLTU: o_result = {{(DATA_W-1){1'b0}}, w_lt_u};
            OP_ADDI: begin
                o_result = w_addi;
                o_ovf    = (i_a[c_msb] == w_imm_sext[c_msb]) && (w_addi[c_msb] != i_a[c_msb]);
            end
            OP_LUI:  o_result = w_lui;
            OP_READ: o_result = i_a;
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rf_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rf_op_sequencer
// Description : Command-driven client of a 32x32 register file. Accepts one
//               ALU/move command, reads operands, executes, writes back and
//               returns the result: IDLE -> READ -> EXEC -> WB -> RESP.
// Ports       : clk, rst (async, active-high)
//               cmd_*  command handshake (cmd_ready high only in IDLE)
//               rf_*   register-file read/write port (initiator side)
//               rsp_*  result handshake (held until rsp_ready)
//               busy   high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [IMM_W-1:0]  cmd_imm,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf,
    output logic              rsp_err,
    output logic              busy
);

    logic [2:0]        r_state;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic [IMM_W-1:0]  r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_ovf;
    logic              r_err;
    logic              r_wb_en;

    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_ovf;
    logic              w_alu_err;

    rf_seq_alu #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (r_imm),
        .o_result (w_alu_result),
        .o_ovf    (w_alu_ovf),
        .o_err    (w_alu_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_wb_en  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_rd    <= cmd_rd;
                        r_rs1   <= cmd_rs1;
                        r_rs2   <= cmd_rs2;
                        r_imm   <= cmd_imm;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // rf_we is low here, so the register file drives its read ports.
                    r_a     <= rf_rdata1;
                    r_b     <= rf_rdata2;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_result <= w_alu_result;
                    r_ovf    <= w_alu_ovf;
                    r_err    <= w_alu_err;
                    // r0 is never written; READ and illegal ops only report.
                    r_wb_en  <= !w_alu_err && (r_rd != '0) && (r_op != OP_READ);
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Decoded from the async-reset state register, so a reset during WB
    // drops rf_we immediately and the write edge never sees it.
    assign rf_we     = (r_state == ST_WB) && r_wb_en;
    assign rf_waddr  = r_rd;
    assign rf_wdata  = r_result;
    assign rf_raddr1 = r_rs1;
    assign rf_raddr2 = r_rs2;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_result;
    assign rsp_ovf   = r_ovf;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rf_op_sequencer
// Description : Scoreboard bench for rf_op_sequencer with a behavioural 32x32
//               register file, directed scenarios and randomized commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_op_sequencer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int IMM_W  = 16;
    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [IMM_W-1:0]  cmd_imm;
    logic [ADDR_W-1:0] rf_raddr1, rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ovf, rsp_err;
    logic              busy;

    always #5 clk = ~clk;

    rf_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy)
    );

    // ---------------- behavioural register file ----------------
    function automatic logic [31:0] init_val(input int i);
        return (i == 0) ? 32'h0 : ((32'h9E37_79B9 * i) ^ 32'h5A5A_0F0F);
    endfunction

    logic [31:0] rf_mem [32];
    logic        rf_load;

    // Read ports only driven while we=0; garbage otherwise exposes bad timing.
    assign rf_rdata1 = rf_we ? 32'hDEAD_BEEF : ((rf_raddr1 == 0) ? 32'h0 : rf_mem[rf_raddr1]);
    assign rf_rdata2 = rf_we ? 32'hDEAD_BEEF : ((rf_raddr2 == 0) ? 32'h0 : rf_mem[rf_raddr2]);

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (rf_we && rf_waddr != 0) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct { logic [31:0] data; logic ovf; logic err; int hs; } rsp_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; int hs; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    logic [31:0] ref_rf [32];
    int ready_mode = 0;   // 0 random, 1 held low, 2 held high

    // Reference semantics with plain integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [15:0] imm, output logic [31:0] res,
                                  output logic ovf, output logic err);
        longint sa, sb, s;
        int     simm;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        simm = int'($signed(imm));
        res = 0; ovf = 0; err = 0;
        case (op)
            4'd0: begin s = sa + sb; res = a + b; ovf = (s > MAX_S) || (s < MIN_S); end
            4'd1: begin s = sa - sb; res = a - b; ovf = (s > MAX_S) || (s < MIN_S); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: res = (a < b) ? 32'd1 : 32'd0;
            4'd7: begin s = sa + longint'(simm); res = a + simm; ovf = (s > MAX_S) || (s < MIN_S); end
            4'd8: res = 32'(imm) * 32'd65536;
            4'd9: res = a;
            default: begin err = 1; res = 0; end
        endcase
    endfunction

    // track=0: the command will be aborted by reset, so no response is
    // expected and the reference register file is left untouched.
    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [15:0] imm, input bit track);
        logic [31:0] res;
        logic        ovf, err;
        int          n;
        rsp_t        r;
        wr_t         w;
        model(op, ref_rf[rs1], ref_rf[rs2], imm, res, ovf, err);
        @(posedge clk); #1;
        cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_accept_timeout");
            cmd_valid = 0;
            return;
        end
        if (track) begin
            r.data = res; r.ovf = ovf; r.err = err; r.hs = cyc;
            rsp_q.push_back(r);
        end
        if (!err && rd != 0 && op != 4'd9) begin
            w.addr = rd; w.data = res; w.hs = cyc;
            wr_q.push_back(w);
            if (track) ref_rf[rd] = res;
        end
        @(posedge clk); #1;
        // Command fields are don't-care after the handshake.
        cmd_valid = 0;
        cmd_op = 4'($urandom); cmd_rd = 5'($urandom); cmd_rs1 = 5'($urandom);
        cmd_rs2 = 5'($urandom); cmd_imm = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((rsp_q.size() != 0 || wr_q.size() != 0 || !cmd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");
    endtask

    // ---------------- rsp_ready driver ----------------
    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                1:       rsp_ready = 0;
                2:       rsp_ready = 1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        pend;
        logic [31:0] held;
        rsp_t        e;
        wr_t         w;
        pend = 0;
        held = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                continue;
            end
            if (rf_we) begin
                if (wr_q.size() == 0) fail_now("unexpected_rf_write");
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(rf_waddr), 32'(w.addr));
                    chk("wr_data", rf_wdata, w.data);
                    chk("wr_cycle", cyc, w.hs + 3);
                end
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) fail_now("unexpected_rsp_valid");
                else begin
                    e = rsp_q[0];
                    if (!pend) chk("rsp_latency", cyc, e.hs + 4);
                    else       chk("rsp_stable", rsp_data, held);
                    held = rsp_data;
                    if (rsp_ready) begin
                        void'(rsp_q.pop_front());
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
            pend = rsp_valid && !rsp_ready;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] old6;
        int          n;
        rst = 1; rf_load = 1;
        cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_rs1 = 0; cmd_rs2 = 0; cmd_imm = 0;
        for (int i = 0; i < 32; i++) ref_rf[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_flags", {30'd0, rsp_ovf, rsp_err}, 0);
        chk("rst_addrs", {17'd0, rf_raddr1, rf_raddr2, rf_waddr}, 0);
        rst = 0; rf_load = 0;

        // Basic writes and back-to-back hazard
        send(4'd7, 5'd1, 5'd0, 5'd0, 16'h0005, 1);   // r1 = 5
        send(4'd7, 5'd2, 5'd0, 5'd0, 16'hFFFF, 1);   // r2 = 0xFFFFFFFF
        send(4'd0, 5'd3, 5'd1, 5'd2, 16'h0000, 1);   // r3 = 4
        send(4'd9, 5'd0, 5'd3, 5'd0, 16'h0000, 1);   // read r3 -> 4
        // 0x80000000 + (-1) gives 0x7FFFFFFF (itself an overflow)
        send(4'd8, 5'd4, 5'd0, 5'd0, 16'h8000, 1);
        send(4'd7, 5'd4, 5'd4, 5'd0, 16'hFFFF, 1);
        send(4'd0, 5'd5, 5'd4, 5'd1, 16'h0000, 1);   // 0x80000004, ovf
        send(4'd0, 5'd0, 5'd1, 5'd1, 16'h0000, 1);   // rd=r0: 10, no write
        send(4'hC, 5'd6, 5'd1, 5'd2, 16'h1234, 1);   // illegal
        wait_idle();
        chk("model_r3", ref_rf[3], 32'd4);
        chk("model_r5", ref_rf[5], 32'h8000_0004);
        chk("rf_r3", rf_mem[3], 32'd4);
        chk("rf_r5", rf_mem[5], 32'h8000_0004);
        chk("rf_r6_untouched", rf_mem[6], init_val(6));

        // Back-pressure on the response
        ready_mode = 1;
        send(4'd0, 5'd7, 5'd1, 5'd1, 16'h0000, 1);   // r7 = 10
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) fail_now("stall_rsp_timeout");
        for (int i = 0; i < 7; i++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 1);
            chk("stall_rsp_data", rsp_data, 32'd10);
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
            chk("stall_busy", 32'(busy), 1);
            @(negedge clk);
        end
        ready_mode = 2;
        @(posedge clk); #2;
        @(posedge clk); #1;
        chk("stall_release_idle", 32'(cmd_ready), 1);
        chk("stall_release_valid", 32'(rsp_valid), 0);
        ready_mode = 0;
        wait_idle();

        // Reset during WB
        old6 = rf_mem[6];
        send(4'd7, 5'd6, 5'd0, 5'd0, 16'h1234, 0);
        n = 0;
        while (!rf_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rf_we) fail_now("wb_wait_timeout");
        #2 rst = 1;
        #1;
        chk("rstwb_rf_we", 32'(rf_we), 0);
        chk("rstwb_cmd_ready", 32'(cmd_ready), 1);
        chk("rstwb_busy", 32'(busy), 0);
        chk("rstwb_rsp_valid", 32'(rsp_valid), 0);
        chk("rstwb_rsp_data", rsp_data, 0);
        chk("rstwb_waddr", 32'(rf_waddr), 0);
        @(posedge clk); #1;
        rst = 0;
        chk("rstwb_r6_unchanged", rf_mem[6], old6);
        send(4'd7, 5'd6, 5'd1, 5'd0, 16'h0003, 1);   // r6 = 8
        send(4'd9, 5'd0, 5'd6, 5'd0, 16'h0000, 1);
        wait_idle();
        chk("rf_r6_after_rst", rf_mem[6], 32'd8);

        // Randomized commands
        for (int k = 0; k < 60; k++) begin
            send(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom), 1);
        end
        wait_idle();
        for (int i = 0; i < 32; i++) chk("final_rf", rf_mem[i], ref_rf[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
